// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: registered main FSM sequencing fetch/decode/execute,
// plus a combinational ALU decoder driven by the FSM's aluop and the instruction funct.
module mips_multicycle_controller #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t     state_q, state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       regwrite_raw;
    logic       illegal_raw;
    logic       funct_ok;
    logic       instr_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        instr_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: instr_illegal = 1'b0;
            OP_RTYPE:                            instr_illegal = ~funct_ok;
            default:                             instr_illegal = 1'b1;
        endcase
    end

    // Main FSM: every datapath control is a Moore function of state_q.
    always_comb begin
        state_d      = S_FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;

        case (state_q)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // The ALU precomputes the branch target while the op is dispatched.
                alusrcb = 2'b11;
                if (instr_illegal) begin
                    illegal_raw = 1'b1;
                    state_d     = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Write enables are squashed during reset so an aborted instruction never commits.
    assign pcen      = ~reset & (pcwrite | (branch & zero));
    assign memwrite  = ~reset & memwrite_raw;
    assign irwrite   = ~reset & irwrite_raw;
    assign regwrite  = ~reset & regwrite_raw;
    assign illegal   = ~reset & illegal_raw;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomised instruction-level bench: a reference model derives the expected state path
// and control word for each instruction class and checks them every cycle.
module tb_mips_multicycle_controller;

    localparam bit TRAP = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];

    mips_multicycle_controller #(.TRAP_ON_ILLEGAL(TRAP)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_illegal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23, 6'h2B, 6'h04, 6'h08, 6'h02: return 1'b0;
            6'h00: return !(f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
            default: return 1'b1;
        endcase
    endfunction

    // Expected state path of one instruction, from fetch to its last cycle.
    function automatic void build_path(input logic [5:0] o, input logic [5:0] f);
        exp_q = {4'd0, 4'd1};
        if (is_illegal(o, f)) begin
            if (TRAP) for (int i = 0; i < 10; i++) exp_q.push_back(4'd12);
        end else begin
            case (o)
                6'h23: exp_q = {exp_q, 4'd2, 4'd3, 4'd4};
                6'h2B: exp_q = {exp_q, 4'd2, 4'd5};
                6'h00: exp_q = {exp_q, 4'd6, 4'd7};
                6'h04: exp_q.push_back(4'd8);
                6'h08: exp_q = {exp_q, 4'd9, 4'd10};
                default: exp_q.push_back(4'd11);
            endcase
        end
    endfunction

    // Control word {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,illegal}
    function automatic logic [15:0] model_out(input logic [3:0] st, input logic [5:0] f,
                                              input logic z, input bit ill);
        logic pe, mw, iw, rw, io, mr, rd, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pe, mw, iw, rw, io, mr, rd, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        case (st)
            4'd0:  begin pe = 1; iw = 1; sb = 2'b01; end
            4'd1:  begin sb = 2'b11; il = ill; end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin mr = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6: begin
                sa = 1;
                case (f)
                    6'h22: ac = 3'b110;
                    6'h24: ac = 3'b000;
                    6'h25: ac = 3'b001;
                    6'h2A: ac = 3'b111;
                    default: ac = 3'b010;
                endcase
            end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {pe, mw, iw, rw, io, mr, rd, sa, sb, ps, ac, il};
    endfunction

    function automatic logic [15:0] dut_out();
        return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};
    endfunction

    task automatic check_reset_gated(input string tag);
        check_eq(tag, {27'd0, pcen, memwrite, irwrite, regwrite, illegal}, 32'd0);
    endtask

    // Runs one instruction; a reset asserted at step abort_at aborts it, and a
    // trapped instruction is released by reset after its HALT cycles.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int abort_at);
        bit ill;
        ill = is_illegal(o, f);
        build_path(o, f);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            reset = 1'b0;
            op    = o;
            funct = f;
            zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset_gated("abort_gate");
                return;
            end
            #1;
            check_eq($sformatf("state[%0d] op=%0h", i, o), {28'd0, state_dbg}, {28'd0, exp_q[i]});
            check_eq($sformatf("ctrl[%0d] op=%0h fn=%0h", i, o, f), {16'd0, dut_out()},
                     {16'd0, model_out(exp_q[i], f, zero, ill)});
        end
        if (exp_q[exp_q.size()-1] == 4'd12) begin
            @(negedge clk);
            reset = 1'b1;
            #1;
            check_reset_gated("halt_reset_gate");
        end
    endtask

    initial begin
        logic [5:0] o, f;
        int r, ab;
        reset = 1'b1; op = 6'h00; funct = 6'h20; zero = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_state", {28'd0, state_dbg}, 32'd0);
        check_reset_gated("reset_gate");

        run_instr(6'h23, 6'h00, -1, -1);
        run_instr(6'h2B, 6'h00, -1, -1);
        run_instr(6'h00, 6'h2A, -1, -1);
        run_instr(6'h04, 6'h00, 1, -1);
        run_instr(6'h04, 6'h00, 0, -1);
        run_instr(6'h08, 6'h11, -1, -1);
        run_instr(6'h02, 6'h00, -1, -1);
        run_instr(6'h3F, 6'h00, -1, -1);
        run_instr(6'h2B, 6'h00, -1, 3);
        run_instr(6'h00, 6'h13, -1, -1);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            f = 6'($urandom_range(0, 63));
            case (r)
                0: o = 6'h23;
                1: o = 6'h2B;
                2, 3: begin
                    o = 6'h00;
                    case ($urandom_range(0, 5))
                        0: f = 6'h20;
                        1: f = 6'h22;
                        2: f = 6'h24;
                        3: f = 6'h25;
                        4: f = 6'h2A;
                        default: ;
                    endcase
                end
                4: o = 6'h04;
                5: o = 6'h08;
                6: o = 6'h02;
                default: o = 6'($urandom_range(0, 63));
            endcase
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, f, -1, ab);
        end

        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("final_state", {28'd0, state_dbg}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
